// File: rtl/game_state_sequencer.sv
// ---------------------------------------------------------------------------
// game_state_sequencer
//
// Frame-rate game sequencer that sits downstream of the collision controller.
// During a frame it collects per-pixel hit and door strobes into pending
// flags. It applies them once per frame, on the clock edge where startOfFrame
// is high (the "commit"). The block owns lives, per-player invulnerability
// windows, the level index and the top-level game FSM.
//
// Optional feature (compile-time macro):
//   TWO_PLAYER_EN  defined   -> player 2 is fully tracked; the game ends
//                               only when both players are out of lives.
//                  undefined -> player2_hit is ignored; lives2 and
//                               player2_invulnerable stay at 0.
//
// Ports
//   clk                   in   system clock
//   reset                 in   asynchronous reset, active-high
//   startOfFrame          in   one-cycle pulse per frame (commit point)
//   start_game            in   one-cycle key pulse
//   player_hit            in   per-pixel hit strobe, player 1
//   player2_hit           in   per-pixel hit strobe, player 2
//   player_door_idol      in   per-pixel strobe, player on the exit door
//   game_state     [2:0]  out  0 IDLE, 1 PLAY, 2 LEVEL_DONE, 3 DYING,
//                              4 GAME_OVER, 5 WIN (also the FSM debug view)
//   lives1, lives2 [2:0]  out  remaining lives
//   player_invulnerable   out  player 1 invulnerability counter != 0
//   player2_invulnerable  out  player 2 invulnerability counter != 0
//   level          [1:0]  out  current level index
//   level_load            out  one-cycle pulse: load the map for `level`
//   freeze                out  high in every state except PLAY
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module game_state_sequencer #(
    parameter int LIVES_INIT    = 3,   // 1..7
    parameter int INVULN_FRAMES = 60,  // >= 1
    parameter int DEATH_FRAMES  = 45,  // >= 1
    parameter int LEVEL_COUNT   = 3    // 1..4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       start_game,
    input  logic       player_hit,
    input  logic       player2_hit,
    input  logic       player_door_idol,
    output logic [2:0] game_state,
    output logic [2:0] lives1,
    output logic [2:0] lives2,
    output logic       player_invulnerable,
    output logic       player2_invulnerable,
    output logic [1:0] level,
    output logic       level_load,
    output logic       freeze
);

    // -----------------------------------------------------------------------
    // Configuration
    // -----------------------------------------------------------------------
`ifdef TWO_PLAYER_EN
    localparam logic P2_EN = 1'b1;
`else
    localparam logic P2_EN = 1'b0;
`endif

    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int DTH_W = $clog2(DEATH_FRAMES + 1);

    localparam logic [INV_W-1:0] INV_LOAD   = INV_W'(INVULN_FRAMES);
    localparam logic [INV_W-1:0] INV_ONE    = INV_W'(1);
    localparam logic [DTH_W-1:0] DTH_LOAD   = DTH_W'(DEATH_FRAMES);
    localparam logic [DTH_W-1:0] DTH_ONE    = DTH_W'(1);
    localparam logic [2:0]       LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [1:0]       LAST_LEVEL = 2'(LEVEL_COUNT - 1);

    // Player 2 loads resolve to zero when player 2 is not tracked, so its
    // lives and invulnerability window never leave zero.
    localparam logic [2:0]       LIVES2_LOAD = P2_EN ? LIVES_LOAD : 3'd0;
    localparam logic [INV_W-1:0] INV2_LOAD   = P2_EN ? INV_LOAD : '0;

    // -----------------------------------------------------------------------
    // FSM encoding (value is exported on game_state)
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PLAY       = 3'd1;
    localparam logic [2:0] ST_LEVEL_DONE = 3'd2;
    localparam logic [2:0] ST_DYING      = 3'd3;
    localparam logic [2:0] ST_GAME_OVER  = 3'd4;
    localparam logic [2:0] ST_WIN        = 3'd5;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]       state_q,  state_d;
    logic [2:0]       lives1_q, lives1_d;
    logic [2:0]       lives2_q, lives2_d;
    logic [INV_W-1:0] inv1_q,   inv1_d;
    logic [INV_W-1:0] inv2_q,   inv2_d;
    logic [DTH_W-1:0] death_q,  death_d;
    logic [1:0]       level_q,  level_d;
    logic             load_q,   load_d;
    logic             freeze_q, freeze_d;
    logic             inv1_flag_q, inv2_flag_q;
    logic             hit1_p_q, hit1_p_d;
    logic             hit2_p_q, hit2_p_d;
    logic             door_p_q, door_p_d;

    // Strobe / commit protocol: there is no valid/ready handshake here.
    // A strobe is any cycle with the input high. It is captured into its
    // pending flag at the end of that cycle. The flag is consumed at the next
    // edge with startOfFrame high. A strobe in the commit cycle itself lands
    // in the flag for the following frame.
    logic commit;
    logic p2_hit_strobe;
    logic stay_in_play;
    logic set_hit1, set_hit2, set_door;

    assign commit        = startOfFrame;
    assign p2_hit_strobe = player2_hit & P2_EN;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        lives1_d = lives1_q;
        lives2_d = lives2_q;
        inv1_d   = inv1_q;
        inv2_d   = inv2_q;
        death_d  = death_q;
        level_d  = level_q;
        load_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_game) begin
                    state_d  = ST_PLAY;
                    lives1_d = LIVES_LOAD;
                    lives2_d = LIVES2_LOAD;
                    level_d  = 2'd0;
                    inv1_d   = INV_LOAD;
                    inv2_d   = INV2_LOAD;
                    load_d   = 1'b1;
                end
            end

            ST_PLAY: begin
                if (commit) begin
                    // Windows age first. A hit in this frame then reloads a
                    // full window, so the window counts from the commit that
                    // took the life.
                    inv1_d = (inv1_q != '0) ? (inv1_q - INV_ONE) : '0;
                    inv2_d = (inv2_q != '0) ? (inv2_q - INV_ONE) : '0;

                    if (hit1_p_q && (lives1_q != 3'd0)) begin
                        lives1_d = lives1_q - 3'd1;
                        inv1_d   = INV_LOAD;
                    end
                    if (hit2_p_q && (lives2_q != 3'd0)) begin
                        lives2_d = lives2_q - 3'd1;
                        inv2_d   = INV2_LOAD;
                    end

                    // lives2_d is always 0 in single-player builds, so only
                    // player 1 decides the death in that case. A death takes
                    // priority over a door seen in the same frame.
                    if ((lives1_d == 3'd0) && (lives2_d == 3'd0)) begin
                        state_d = ST_DYING;
                        death_d = DTH_LOAD;
                    end else if (door_p_q) begin
                        state_d = ST_LEVEL_DONE;
                    end
                end
            end

            ST_LEVEL_DONE: begin
                if (commit) begin
                    if (level_q == LAST_LEVEL) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_PLAY;
                        level_d = level_q + 2'd1;
                        inv1_d  = INV_LOAD;
                        inv2_d  = INV2_LOAD;
                        load_d  = 1'b1;
                    end
                end
            end

            ST_DYING: begin
                if (commit) begin
                    death_d = (death_q != '0) ? (death_q - DTH_ONE) : '0;
                    if (death_d == '0) begin
                        state_d = ST_GAME_OVER;
                    end
                end
            end

            ST_GAME_OVER, ST_WIN: begin
                if (start_game) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pending flags
    // -----------------------------------------------------------------------
    // A strobe counts only if the game is in PLAY now and stays there. It
    // also needs the player to be alive and not invulnerable after this edge.
    // Using the post-edge values stops a strobe in the commit cycle from
    // arming a hit that the same commit has just covered with a new window.
    always_comb begin
        stay_in_play = (state_q == ST_PLAY) && (state_d == ST_PLAY);
        set_hit1     = stay_in_play && player_hit &&
                       (inv1_d == '0) && (lives1_d != 3'd0);
        set_hit2     = stay_in_play && p2_hit_strobe &&
                       (inv2_d == '0) && (lives2_d != 3'd0);
        set_door     = stay_in_play && player_door_idol;

        hit1_p_d = (commit ? 1'b0 : hit1_p_q) | set_hit1;
        hit2_p_d = (commit ? 1'b0 : hit2_p_q) | set_hit2;
        door_p_d = (commit ? 1'b0 : door_p_q) | set_door;

        freeze_d = (state_d != ST_PLAY);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lives1_q    <= 3'd0;
            lives2_q    <= 3'd0;
            inv1_q      <= '0;
            inv2_q      <= '0;
            death_q     <= '0;
            level_q     <= 2'd0;
            load_q      <= 1'b0;
            freeze_q    <= 1'b1;
            inv1_flag_q <= 1'b0;
            inv2_flag_q <= 1'b0;
            hit1_p_q    <= 1'b0;
            hit2_p_q    <= 1'b0;
            door_p_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives1_q    <= lives1_d;
            lives2_q    <= lives2_d;
            inv1_q      <= inv1_d;
            inv2_q      <= inv2_d;
            death_q     <= death_d;
            level_q     <= level_d;
            load_q      <= load_d;
            freeze_q    <= freeze_d;
            inv1_flag_q <= (inv1_d != '0);
            inv2_flag_q <= (inv2_d != '0);
            hit1_p_q    <= hit1_p_d;
            hit2_p_q    <= hit2_p_d;
            door_p_q    <= door_p_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign game_state           = state_q;
    assign lives1               = lives1_q;
    assign lives2               = lives2_q;
    assign player_invulnerable  = inv1_flag_q;
    assign player2_invulnerable = inv2_flag_q;
    assign level                = level_q;
    assign level_load           = load_q;
    assign freeze               = freeze_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_state_sequencer
//
// Directed bench for game_state_sequencer with default parameters
// (LIVES_INIT 3, INVULN_FRAMES 60, DEATH_FRAMES 45, LEVEL_COUNT 3). Each
// expected output snapshot is pushed into exp_q by the stimulus thread. The
// negedge monitor pops each snapshot and compares it with the DUT outputs,
// together with a running count of level_load pulses.
// ---------------------------------------------------------------------------
module tb_game_state_sequencer;

`ifdef TWO_PLAYER_EN
    localparam logic TP = 1'b1;
`else
    localparam logic TP = 1'b0;
`endif

    localparam int W = 22;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_LDONE = 3'd2;
    localparam logic [2:0] S_DYING = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic       start_game;
    logic       player_hit;
    logic       player2_hit;
    logic       player_door_idol;
    logic [2:0] game_state;
    logic [2:0] lives1;
    logic [2:0] lives2;
    logic       player_invulnerable;
    logic       player2_invulnerable;
    logic [1:0] level;
    logic       level_load;
    logic       freeze;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   ll_cnt   = 8'd0;

    game_state_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .startOfFrame         (startOfFrame),
        .start_game           (start_game),
        .player_hit           (player_hit),
        .player2_hit          (player2_hit),
        .player_door_idol     (player_door_idol),
        .game_state           (game_state),
        .lives1               (lives1),
        .lives2               (lives2),
        .player_invulnerable  (player_invulnerable),
        .player2_invulnerable (player2_invulnerable),
        .level                (level),
        .level_load           (level_load),
        .freeze               (freeze)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        string        nm;
        if (level_load === 1'b1) ll_cnt = ll_cnt + 8'd1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {game_state, lives1, lives2, player_invulnerable,
                   player2_invulnerable, level, freeze, ll_cnt};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: actual state=%0d lives1=%0d lives2=%0d inv1=%0d inv2=%0d level=%0d freeze=%0d loads=%0d, expected state=%0d lives1=%0d lives2=%0d inv1=%0d inv2=%0d level=%0d freeze=%0d loads=%0d",
                         nm, act[21:19], act[18:16], act[15:13], act[12], act[11],
                         act[10:9], act[8], act[7:0],
                         exp[21:19], exp[18:16], exp[15:13], exp[12], exp[11],
                         exp[10:9], exp[8], exp[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] gs, input logic [2:0] l1,
                       input logic [2:0] l2, input logic i1, input logic i2,
                       input logic [1:0] lvl, input logic frz, input logic [7:0] ll);
        exp_q.push_back({gs, l1, l2, i1, i2, lvl, frz, ll});
        name_q.push_back(nm);
    endtask

    function automatic logic [2:0] p2l(input logic [2:0] x);
        return TP ? x : 3'd0;
    endfunction

    task automatic pulse_start();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            repeat (3) tick();
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
        end
    endtask

    // Ten strobes on the selected hit lines, an optional door strobe,
    // then the commit.
    task automatic hit_frame(input logic h1, input logic h2, input logic door);
        repeat (10) begin
            player_hit  = h1;
            player2_hit = h2;
            tick();
            player_hit  = 1'b0;
            player2_hit = 1'b0;
            tick();
        end
        if (door) begin
            player_door_idol = 1'b1;
            tick();
            player_door_idol = 1'b0;
        end
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    // From fresh PLAY at level 0 with full lives and fresh windows: drain the
    // window, hit both lines, three times. The last hit carries a door too.
    task automatic run_to_dying(input logic [7:0] ll);
        for (int k = 2; k >= 0; k--) begin
            frames(60);
            chk("drain", S_PLAY, 3'(k + 1), p2l(3'(k + 1)), 1'b0, 1'b0, 2'd0, 1'b0, ll);
            hit_frame(1'b1, 1'b1, k == 0);
            if (k > 0)
                chk("both_hit", S_PLAY, 3'(k), p2l(3'(k)), 1'b1, TP, 2'd0, 1'b0, ll);
            else
                chk("hit_door_dying", S_DYING, 3'd0, 3'd0, 1'b1, TP, 2'd0, 1'b1, ll);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached with %0d checks queued", exp_q.size());
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset            = 1'b1;
        startOfFrame     = 1'b0;
        start_game       = 1'b0;
        player_hit       = 1'b0;
        player2_hit      = 1'b0;
        player_door_idol = 1'b0;
        repeat (3) tick();
        chk("reset", S_IDLE, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("post_reset", S_IDLE, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd0);

        // 1) start game
        pulse_start();
        chk("start", S_PLAY, 3'd3, p2l(3'd3), 1'b1, TP, 2'd0, 1'b0, 8'd1);
        frames(5);
        chk("five_frames", S_PLAY, 3'd3, p2l(3'd3), 1'b1, TP, 2'd0, 1'b0, 8'd1);
        pulse_start();
        chk("start_ignored_play", S_PLAY, 3'd3, p2l(3'd3), 1'b1, TP, 2'd0, 1'b0, 8'd1);

        // 2) windows expire, then one hit frame with ten strobes
        frames(56);
        chk("window_expired", S_PLAY, 3'd3, p2l(3'd3), 1'b0, 1'b0, 2'd0, 1'b0, 8'd1);
        hit_frame(1'b1, 1'b0, 1'b0);
        chk("single_decrement", S_PLAY, 3'd2, p2l(3'd3), 1'b1, 1'b0, 2'd0, 1'b0, 8'd1);
        repeat (3) hit_frame(1'b1, 1'b0, 1'b0);
        chk("hits_masked", S_PLAY, 3'd2, p2l(3'd3), 1'b1, 1'b0, 2'd0, 1'b0, 8'd1);
        frames(56);
        chk("window_last_frame", S_PLAY, 3'd2, p2l(3'd3), 1'b1, 1'b0, 2'd0, 1'b0, 8'd1);
        frames(1);
        chk("window_end", S_PLAY, 3'd2, p2l(3'd3), 1'b0, 1'b0, 2'd0, 1'b0, 8'd1);

        // 6a) strobe coincident with the commit belongs to the next frame
        player_hit   = 1'b1;
        startOfFrame = 1'b1;
        tick();
        player_hit   = 1'b0;
        startOfFrame = 1'b0;
        chk("coincident_deferred", S_PLAY, 3'd2, p2l(3'd3), 1'b0, 1'b0, 2'd0, 1'b0, 8'd1);
        frames(1);
        chk("coincident_counted", S_PLAY, 3'd1, p2l(3'd3), 1'b1, 1'b0, 2'd0, 1'b0, 8'd1);

        // 3) doors through all levels to WIN
        hit_frame(1'b0, 1'b0, 1'b1);
        chk("door_l0", S_LDONE, 3'd1, p2l(3'd3), 1'b1, 1'b0, 2'd0, 1'b1, 8'd1);
        frames(1);
        chk("level1", S_PLAY, 3'd1, p2l(3'd3), 1'b1, TP, 2'd1, 1'b0, 8'd2);
        hit_frame(1'b0, 1'b0, 1'b1);
        chk("door_l1", S_LDONE, 3'd1, p2l(3'd3), 1'b1, TP, 2'd1, 1'b1, 8'd2);
        frames(1);
        chk("level2", S_PLAY, 3'd1, p2l(3'd3), 1'b1, TP, 2'd2, 1'b0, 8'd3);
        hit_frame(1'b0, 1'b0, 1'b1);
        chk("door_l2", S_LDONE, 3'd1, p2l(3'd3), 1'b1, TP, 2'd2, 1'b1, 8'd3);
        frames(1);
        chk("win", S_WIN, 3'd1, p2l(3'd3), 1'b1, TP, 2'd2, 1'b1, 8'd3);
        pulse_start();
        chk("win_to_idle", S_IDLE, 3'd1, p2l(3'd3), 1'b1, TP, 2'd2, 1'b1, 8'd3);

        // 4) lose all lives; hit and door together on the last life -> DYING
        pulse_start();
        chk("restart", S_PLAY, 3'd3, p2l(3'd3), 1'b1, TP, 2'd0, 1'b0, 8'd4);
        run_to_dying(8'd4);
        frames(20);
        pulse_start();
        chk("start_ignored_dying", S_DYING, 3'd0, 3'd0, 1'b1, TP, 2'd0, 1'b1, 8'd4);
        frames(24);
        chk("dying_44", S_DYING, 3'd0, 3'd0, 1'b1, TP, 2'd0, 1'b1, 8'd4);
        frames(1);
        chk("game_over", S_OVER, 3'd0, 3'd0, 1'b1, TP, 2'd0, 1'b1, 8'd4);
        pulse_start();
        chk("over_to_idle", S_IDLE, 3'd0, 3'd0, 1'b1, TP, 2'd0, 1'b1, 8'd4);
        pulse_start();
        chk("restart2", S_PLAY, 3'd3, p2l(3'd3), 1'b1, TP, 2'd0, 1'b0, 8'd5);

`ifdef TWO_PLAYER_EN
        // 5) player 1 dies alone, then player 2
        for (int k = 2; k >= 0; k--) begin
            frames(60);
            hit_frame(1'b1, 1'b0, 1'b0);
            chk("kill_p1", S_PLAY, 3'(k), 3'd3, 1'b1, 1'b0, 2'd0, 1'b0, 8'd5);
        end
        for (int k = 2; k >= 0; k--) begin
            frames(60);
            hit_frame(1'b0, 1'b1, 1'b0);
            if (k > 0)
                chk("kill_p2", S_PLAY, 3'd0, 3'(k), 1'b0, 1'b1, 2'd0, 1'b0, 8'd5);
            else
                chk("both_dead", S_DYING, 3'd0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b1, 8'd5);
        end
`else
        run_to_dying(8'd5);
`endif

        // 6b) asynchronous reset in the middle of DYING
        frames(10);
        reset = 1'b1;
        #2;
        chk("async_reset", S_IDLE, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd5);
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("no_load_on_release", S_IDLE, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd5);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            $display("FAIL drain: actual %0d checks left, expected 0", exp_q.size());
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
